// File: rtl/sprite_ram_arbiter.sv
// Purpose : shares one synchronous-read sprite RAM between two pixel-fetch readers
//           (round-robin) and one sprite-loader writer.
// Latency : read grant is combinational, and the tagged read data returns exactly one cycle later.
// Backpressure: a write is held off (wr_gnt=0) while it hits the read address issued
//           that cycle. After 15 held cycles, the next cycle masks both reads and
//           forces the write through.
// Ports   : Clk/Reset_n (async, active-low); rd0_*/rd1_* reader req/addr/gnt/valid/data;
//           wr_* loader req/addr/data/gnt; blank; ram_* connect to the RAM macro.
// Option  : define SPRITE_ARB_BLANK_WRITE_EN to restrict writes (and the forced-write
//           override) to blanking. When it is undefined, blank is ignored.
`timescale 1ns/1ps
module sprite_ram_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int WDATA_W = 24,
  parameter int RDATA_W = 5
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               rd0_req,
  input  logic [ADDR_W-1:0]  rd0_addr,
  output logic               rd0_gnt,
  output logic               rd0_valid,
  output logic [RDATA_W-1:0] rd0_data,
  input  logic               rd1_req,
  input  logic [ADDR_W-1:0]  rd1_addr,
  output logic               rd1_gnt,
  output logic               rd1_valid,
  output logic [RDATA_W-1:0] rd1_data,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WDATA_W-1:0] wr_data,
  output logic               wr_gnt,
  input  logic               blank,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_write_address,
  output logic [ADDR_W-1:0]  ram_read_address,
  output logic [WDATA_W-1:0] ram_data_In,
  input  logic [RDATA_W-1:0] ram_data_Out
);

  logic              r_rr;        // favoured reader when both request
  logic              r_tag_v;     // a read was issued last cycle
  logic              r_tag_id;    // which reader issued it
  logic [3:0]        r_coll_cnt;  // consecutive held-off write cycles
  logic [ADDR_W-1:0] r_rd_addr;   // last driven read address

  logic              w_wr_window;
  logic              w_force;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any_gnt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_collide;
  logic              w_wr_gnt;
  logic              w_held;

`ifdef SPRITE_ARB_BLANK_WRITE_EN
  assign w_wr_window = blank;
`else
  // Writes are allowed during active video. blank is read here only so the port is not left dangling.
  assign w_wr_window = blank | 1'b1;
`endif

  // The loader has been starved long enough: give the RAM cycle to the write.
  assign w_force = Reset_n && wr_req && w_wr_window && (r_coll_cnt == 4'd15);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (Reset_n && !w_force) begin
      if (rd0_req && (!rd1_req || !r_rr)) begin
        w_gnt0 = 1'b1;
      end else if (rd1_req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;

  // Hold the last issued address when idle so the RAM read port does not toggle.
  assign w_rd_addr = w_gnt0 ? rd0_addr :
                     w_gnt1 ? rd1_addr : r_rd_addr;

  assign w_collide = w_any_gnt && (wr_addr == w_rd_addr);
  assign w_wr_gnt  = Reset_n && wr_req && w_wr_window && !w_collide;
  assign w_held    = wr_req && w_wr_window && w_collide;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr       <= 1'b0;
      r_tag_v    <= 1'b0;
      r_tag_id   <= 1'b0;
      r_coll_cnt <= 4'd0;
      r_rd_addr  <= '0;
    end else begin
      r_tag_v  <= w_any_gnt;
      r_tag_id <= w_gnt1;
      if (w_any_gnt) begin
        r_rd_addr <= w_rd_addr;
      end
      // Only a contested grant moves the round-robin pointer.
      if (rd0_req && rd1_req && w_any_gnt) begin
        r_rr <= ~r_rr;
      end
      if (w_wr_gnt) begin
        r_coll_cnt <= 4'd0;
      end else if (w_held && (r_coll_cnt != 4'd15)) begin
        r_coll_cnt <= r_coll_cnt + 4'd1;
      end
    end
  end

  assign rd0_gnt           = w_gnt0;
  assign rd1_gnt           = w_gnt1;
  assign ram_read_address  = w_rd_addr;
  assign rd0_valid         = r_tag_v && !r_tag_id;
  assign rd1_valid         = r_tag_v &&  r_tag_id;
  assign rd0_data          = ram_data_Out;
  assign rd1_data          = ram_data_Out;
  assign wr_gnt            = w_wr_gnt;
  assign ram_we            = w_wr_gnt;
  assign ram_write_address = wr_addr;
  assign ram_data_In       = wr_data;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
`timescale 1ns/1ps
module tb_sprite_ram_arbiter;

  localparam int AW = 19;
  localparam int WW = 24;
  localparam int RW = 5;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          rd0_req, rd1_req, wr_req, blank;
  logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
  logic [WW-1:0] wr_data;
  logic          rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, wr_gnt, ram_we;
  logic [RW-1:0] rd0_data, rd1_data, ram_data_Out;
  logic [AW-1:0] ram_write_address, ram_read_address;
  logic [WW-1:0] ram_data_In;

  int n_checks = 0;
  int n_errors = 0;

  sprite_ram_arbiter #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .blank(blank),
    .ram_we(ram_we), .ram_write_address(ram_write_address),
    .ram_read_address(ram_read_address), .ram_data_In(ram_data_In),
    .ram_data_Out(ram_data_Out)
  );

  always #5 Clk = ~Clk;

  // Unwritten RAM locations hold a fixed address-derived pattern.
  function automatic logic [RW-1:0] init_val(input logic [AW-1:0] a);
    return a[4:0] ^ 5'h0A;
  endfunction

  // RAM stub: synchronous read with one-cycle latency and a separate write port.
  logic [WW-1:0] ram_mem [logic [AW-1:0]];
  logic [RW-1:0] ram_q;
  assign ram_data_Out = ram_q;
  always @(posedge Clk) begin
    ram_q = ram_mem.exists(ram_read_address) ? ram_mem[ram_read_address][4:0]
                                             : init_val(ram_read_address);
    if (ram_we) ram_mem[ram_write_address] = ram_data_In;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [WW-1:0] mdl_mem [logic [AW-1:0]];
  int            m_fav, m_cnt, m_tag_id;
  bit            m_tag_v;
  logic [RW-1:0] m_tag_dat;
  logic [AW-1:0] m_last;

  function automatic logic [RW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a][4:0] : init_val(a);
  endfunction

  initial begin
    int            n_fav, n_cnt, n_tag_id, win;
    bit            n_tag_v, n_wr, window, force_w, hit, wok;
    logic [RW-1:0] n_tag_dat;
    logic [AW-1:0] n_last, raddr, n_wa;
    logic [WW-1:0] n_wd;
    m_fav = 0; m_cnt = 0; m_tag_v = 0; m_tag_id = 0; m_tag_dat = '0; m_last = '0;
    n_fav = 0; n_cnt = 0; n_tag_v = 0; n_tag_id = 0; n_tag_dat = '0; n_last = '0;
    n_wr = 0; n_wa = '0; n_wd = '0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        chk("rst_rd0_gnt", 32'(rd0_gnt), 32'(1'b0));
        chk("rst_rd1_gnt", 32'(rd1_gnt), 32'(1'b0));
        chk("rst_wr_gnt", 32'(wr_gnt), 32'(1'b0));
        chk("rst_ram_we", 32'(ram_we), 32'(1'b0));
        chk("rst_rd0_valid", 32'(rd0_valid), 32'(1'b0));
        chk("rst_rd1_valid", 32'(rd1_valid), 32'(1'b0));
        chk("rst_rd_addr", 32'(ram_read_address), 32'(0));
        n_wr = 0;
      end else begin
`ifdef SPRITE_ARB_BLANK_WRITE_EN
        window = blank;
`else
        window = 1'b1;
`endif
        // Who owns the read port this cycle.
        force_w = (m_cnt == 15) && wr_req && window;
        win = -1;
        if (!force_w) begin
          if (rd0_req && rd1_req) win = m_fav;
          else if (rd0_req)       win = 0;
          else if (rd1_req)       win = 1;
        end
        raddr = (win == 0) ? rd0_addr : (win == 1) ? rd1_addr : m_last;
        hit   = (win >= 0) && (wr_addr == raddr);
        wok   = wr_req && window && !hit;

        chk("rd0_gnt", 32'(rd0_gnt), 32'(win == 0));
        chk("rd1_gnt", 32'(rd1_gnt), 32'(win == 1));
        chk("wr_gnt", 32'(wr_gnt), 32'(wok));
        chk("ram_we", 32'(ram_we), 32'(wok));
        chk("ram_read_address", 32'(ram_read_address), 32'(raddr));
        if (wok) begin
          chk("ram_write_address", 32'(ram_write_address), 32'(wr_addr));
          chk("ram_data_In", 32'(ram_data_In), 32'(wr_data));
        end
        chk("rd0_valid", 32'(rd0_valid), 32'(m_tag_v && m_tag_id == 0));
        chk("rd1_valid", 32'(rd1_valid), 32'(m_tag_v && m_tag_id == 1));
        if (m_tag_v && m_tag_id == 0) chk("rd0_data", 32'(rd0_data), 32'(m_tag_dat));
        if (m_tag_v && m_tag_id == 1) chk("rd1_data", 32'(rd1_data), 32'(m_tag_dat));

        n_tag_v   = (win >= 0);
        n_tag_id  = (win == 1) ? 1 : 0;
        n_tag_dat = mdl_rd(raddr);
        n_last    = raddr;
        n_fav     = (rd0_req && rd1_req && win >= 0) ? 1 - win : m_fav;
        if (wok)                        n_cnt = 0;
        else if (wr_req && window && hit) n_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        else                            n_cnt = m_cnt;
        n_wr = wok; n_wa = wr_addr; n_wd = wr_data;
      end
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        m_fav = 0; m_cnt = 0; m_tag_v = 0; m_tag_id = 0; m_last = '0;
      end else begin
        m_fav = n_fav; m_cnt = n_cnt; m_tag_v = n_tag_v; m_tag_id = n_tag_id;
        m_tag_dat = n_tag_dat; m_last = n_last;
        if (n_wr) mdl_mem[n_wa] = n_wd;
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    rd0_req = 0; rd1_req = 0; wr_req = 0;
  endtask

  initial begin
    logic [RW-1:0] lit_sr [4];
    lit_sr[0] = 5'h0A; lit_sr[1] = 5'h0B; lit_sr[2] = 5'h08; lit_sr[3] = 5'h09;

    // Reset state, with requests asserted to prove the grants are gated.
    Reset_n = 0; blank = 1;
    rd0_req = 1; rd0_addr = 19'h00007; rd1_req = 0; rd1_addr = '0;
    wr_req = 1; wr_addr = 19'h00009; wr_data = 24'h000001;
    @(negedge Clk);
    chk("lit_rst_rd0_gnt", 32'(rd0_gnt), 32'(1'b0));
    chk("lit_rst_wr_gnt", 32'(wr_gnt), 32'(1'b0));
    chk("lit_rst_rd_addr", 32'(ram_read_address), 32'h0);
    tick();
    idle(); Reset_n = 1;
    tick();

    // Reset arriving while a read is in flight discards its tag.
    rd0_req = 1; rd0_addr = 19'h00100;
    @(negedge Clk);
    chk("lit_midrst_gnt", 32'(rd0_gnt), 32'(1'b1));
    #2 Reset_n = 0;
    rd0_req = 0;
    tick(); tick();
    Reset_n = 1;
    @(negedge Clk);
    chk("lit_midrst_valid", 32'(rd0_valid), 32'(1'b0));
    tick();
    @(negedge Clk);
    chk("lit_midrst_valid2", 32'(rd0_valid), 32'(1'b0));
    tick();

    // Single reader streaming 0x000..0x003.
    rd0_req = 1;
    for (int i = 0; i < 4; i++) begin
      rd0_addr = 19'(i);
      @(negedge Clk);
      chk("lit_sr_gnt", 32'(rd0_gnt), 32'(1'b1));
      chk("lit_sr_rd1_valid", 32'(rd1_valid), 32'(1'b0));
      if (i > 0) begin
        chk("lit_sr_valid", 32'(rd0_valid), 32'(1'b1));
        chk("lit_sr_data", 32'(rd0_data), 32'(lit_sr[i-1]));
      end
      tick();
    end
    rd0_req = 0;
    @(negedge Clk);
    chk("lit_sr_data_last", 32'(rd0_data), 32'(lit_sr[3]));
    tick();

    // Contention: both readers for 6 cycles, grants must alternate from reader 0.
    rd0_req = 1; rd0_addr = 19'h00010; rd1_req = 1; rd1_addr = 19'h00020;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("lit_ct_gnt0", 32'(rd0_gnt), 32'(i % 2 == 0));
      chk("lit_ct_gnt1", 32'(rd1_gnt), 32'(i % 2 == 1));
      if (i > 0) chk("lit_ct_valid1", 32'(rd1_valid), 32'(i % 2 == 0));
      tick();
    end
    idle();
    @(negedge Clk);
    chk("lit_ct_last_valid1", 32'(rd1_valid), 32'(1'b1));
    tick();

    // Collision with the granted read address, then release and read back.
    rd0_req = 1; rd0_addr = 19'h00050;
    wr_req = 1; wr_addr = 19'h00050; wr_data = 24'h000013;
    @(negedge Clk);
    chk("lit_col_held", 32'(wr_gnt), 32'(1'b0));
    tick();
    rd0_addr = 19'h00051;
    @(negedge Clk);
    chk("lit_col_wr_gnt", 32'(wr_gnt), 32'(1'b1));
    chk("lit_col_we", 32'(ram_we), 32'(1'b1));
    chk("lit_col_rd_par", 32'(rd0_gnt), 32'(1'b1));
    tick();
    wr_req = 0; rd0_addr = 19'h00050;
    tick();
    rd0_req = 0;
    @(negedge Clk);
    chk("lit_col_readback", 32'(rd0_data), 32'h13);
    tick();

    // Starvation: both readers camp on the write address.
    rd0_req = 1; rd1_req = 1; rd0_addr = 19'h00050; rd1_addr = 19'h00050;
    wr_req = 1; wr_addr = 19'h00050; wr_data = 24'hABC01F;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      chk("lit_stv_held", 32'(wr_gnt), 32'(1'b0));
      tick();
    end
    @(negedge Clk);
    chk("lit_stv_gnt0", 32'(rd0_gnt), 32'(1'b0));
    chk("lit_stv_gnt1", 32'(rd1_gnt), 32'(1'b0));
    chk("lit_stv_wr_gnt", 32'(wr_gnt), 32'(1'b1));
    tick();
    wr_req = 0; rd1_req = 0;
    tick();
    rd0_req = 0;
    @(negedge Clk);
    chk("lit_stv_readback", 32'(rd0_data), 32'h1F);
    tick();

`ifdef SPRITE_ARB_BLANK_WRITE_EN
    // Writes wait for blanking.
    blank = 0; wr_req = 1; wr_addr = 19'h00200; wr_data = 24'h000005;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("lit_blank_held", 32'(wr_gnt), 32'(1'b0));
      tick();
    end
    blank = 1;
    @(negedge Clk);
    chk("lit_blank_gnt", 32'(wr_gnt), 32'(1'b1));
    tick();
`else
    // Blank is ignored: a non-colliding write goes through in active video.
    blank = 0; wr_req = 1; wr_addr = 19'h00200; wr_data = 24'h000005;
    @(negedge Clk);
    chk("lit_active_wr_gnt", 32'(wr_gnt), 32'(1'b1));
    tick();
    blank = 1;
`endif
    idle();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
